// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM encodings shared by the arbiter and the alu.
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/and/or/slt; undefined opcodes give zero with co=0.
module alu
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]   op,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic [n-1:0] z,
  output logic         co,
  output logic         zero
);
  logic [n:0] sum, dif;
  assign sum  = {1'b0, x} + {1'b0, y};
  assign dif  = {1'b0, x} - {1'b0, y};
  assign zero = (z == '0);
  always_comb begin
    {co, z} = op == ALU_ADD ? sum :
              op == ALU_SUB ? dif :
              op == ALU_AND ? {1'b0, x & y} :
              op == ALU_OR  ? {1'b0, x | y} :
              op == ALU_SLT ? {{n{1'b0}}, x < y} : '0;
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one alu between two valid/ready
// requesters, with a registered result held until the consumer accepts it.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_z,
  output logic         rsp_co,
  output logic         rsp_zero,
  output logic         busy
);
  state_t state_q, state_d;
  logic rr_q, id_q, rsp_id_q, co_q, zero_q;
  logic [2:0] op_q;
  logic [N-1:0] x_q, y_q, z_q, alu_z;
  logic alu_co, alu_zero, win, grant;
  // A grant is possible when idle or when the held result is being accepted.
  assign grant = rst_n && (req0_valid || req1_valid) &&
                 (state_q == ST_IDLE || (state_q == ST_RESP && rsp_ready));
  assign win = (req0_valid && req1_valid) ? rr_q : req1_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ST_EXEC ? ST_RESP :
              grant ? ST_EXEC :
              (state_q == ST_RESP && !rsp_ready) ? ST_RESP : ST_IDLE;
  end
  always_comb begin
    req0_ready = grant && !win;
    req1_ready = grant && win;
    rsp_valid  = state_q == ST_RESP;
    busy       = state_q != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      co_q     <= 1'b0;
      zero_q   <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      if (grant) begin
        rr_q <= !win;
        id_q <= win;
        op_q <= win ? req1_op : req0_op;
        x_q  <= win ? req1_x : req0_x;
        y_q  <= win ? req1_y : req0_y;
      end
      if (state_q == ST_EXEC) begin
        z_q      <= alu_z;
        co_q     <= alu_co;
        zero_q   <= alu_zero;
        rsp_id_q <= id_q;
      end
    end
  end
  alu #(.n(N)) u_alu (
    .op  (op_q),
    .x   (x_q),
    .y   (y_q),
    .z   (alu_z),
    .co  (alu_co),
    .zero(alu_zero)
  );
  assign rsp_z    = z_q;
  assign rsp_co   = co_q;
  assign rsp_zero = zero_q;
  assign rsp_id   = rsp_id_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of arbitration, latency, backpressure and alu results.
module tb_alu_share_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_co, rsp_zero, busy;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0, rsp_z;
  int n_chk = 0, n_fail = 0;

  alu_share_arb #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_co(rsp_co), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int k;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y; end
    else begin req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y; end
    #1;
    k = 0;
    while (!(id ? req1_ready : req0_ready) && k < 20) begin cyc(); k++; end
    n_chk++;
    if (k >= 20) begin n_fail++; $display("FAIL issue_timeout: ready never seen for req%0d", id); end
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    n_chk++;
    if ({rsp_valid, busy, rsp_id, rsp_co, rsp_zero, rsp_z} !== 37'd0) begin
      n_fail++; $display("FAIL reset_init: got %h expected 0", {rsp_valid, busy, rsp_id, rsp_co, rsp_zero, rsp_z});
    end
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    cyc();
    n_chk++;
    if ({rsp_valid, rsp_z} !== {1'b1, 32'h0000_00FF}) begin
      n_fail++; $display("FAIL reset_pre_resp: got v=%b z=%h expected v=1 z=000000ff", rsp_valid, rsp_z);
    end
    rst_n = 1'b0;
    cyc(); cyc();
    n_chk++;
    if ({rsp_valid, busy, rsp_id, rsp_co, rsp_zero, rsp_z} !== 37'd0) begin
      n_fail++; $display("FAIL reset_mid_resp: got %h expected 0", {rsp_valid, busy, rsp_id, rsp_co, rsp_zero, rsp_z});
    end
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL reset_rr_ptr: got ready=%b expected 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_grant: got busy=%b expected 0", busy); end
  endtask

  task automatic test_contention();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_x = 32'd10; req0_y = 32'd20;
    req1_valid = 1'b1; req1_op = 3'b011; req1_x = 32'h0000_00F0; req1_y = 32'h0000_000F;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({req0_ready, req1_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL cont_grant%0d: got ready=%b expected %b", i, {req0_ready, req1_ready}, (i % 2) ? 2'b01 : 2'b10);
      end
      cyc();
      n_chk++;
      if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0001) begin
        n_fail++; $display("FAIL cont_exec%0d: got r0,r1,v,busy=%b expected 0001", i, {req0_ready, req1_ready, rsp_valid, busy});
      end
      cyc();
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_co, rsp_z} !== {1'b1, i[0], 1'b0, (i % 2) ? 32'h0000_00FF : 32'd30}) begin
        n_fail++; $display("FAIL cont_resp%0d: got v=%b id=%b co=%b z=%h", i, rsp_valid, rsp_id, rsp_co, rsp_z);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    n_chk++;
    if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL cont_idle: got v,busy=%b expected 00", {rsp_valid, busy}); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_x = 32'hFFFF_FFFF; req0_y = 32'd1;
    #1;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready}); end
    cyc();
    req0_valid = 1'b0;
    n_chk++;
    if ({req0_ready, rsp_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL single_exec: got %b expected 001", {req0_ready, rsp_valid, busy}); end
    cyc();
    n_chk++;
    if ({rsp_valid, rsp_z, rsp_co, rsp_zero, rsp_id} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: got v=%b z=%h co=%b zero=%b id=%b expected 1 0 1 1 0", rsp_valid, rsp_z, rsp_co, rsp_zero, rsp_id);
    end
    cyc();
    n_chk++;
    if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b expected 00", {rsp_valid, busy}); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b1, 3'b001, 32'd5, 32'd7);
    cyc();
    req0_valid = 1'b1; req0_op = 3'b000; req0_x = 32'd1; req0_y = 32'd1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({rsp_valid, rsp_id, rsp_co, rsp_z, req0_ready, req1_ready} !== {1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b id=%b co=%b z=%h r=%b", i, rsp_valid, rsp_id, rsp_co, rsp_z, {req0_ready, req1_ready});
      end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b expected 10", {req0_ready, req1_ready}); end
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 1'b0, 32'd2}) begin
      n_fail++; $display("FAIL bp_next: got v=%b id=%b z=%h expected 1 0 2", rsp_valid, rsp_id, rsp_z);
    end
    cyc();
  endtask

  task automatic test_slt_undef();
    rsp_ready = 1'b1;
    issue(1'b1, 3'b101, 32'd3, 32'd9);
    cyc();
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_co, rsp_zero} !== {1'b1, 1'b1, 32'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL slt: got v=%b id=%b z=%h co=%b zero=%b", rsp_valid, rsp_id, rsp_z, rsp_co, rsp_zero);
    end
    cyc();
    issue(1'b1, 3'b111, 32'd3, 32'd9);
    cyc();
    n_chk++;
    if ({rsp_valid, rsp_z, rsp_co, rsp_zero} !== {1'b1, 32'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL undef: got v=%b z=%h co=%b zero=%b expected 1 0 0 1", rsp_valid, rsp_z, rsp_co, rsp_zero);
    end
    cyc();
    issue(1'b0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    cyc();
    n_chk++;
    if ({rsp_z, rsp_co, rsp_zero, rsp_id} !== {32'h0000_F000, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL and: got z=%h co=%b zero=%b id=%b", rsp_z, rsp_co, rsp_zero, rsp_id);
    end
    cyc();
  endtask

  initial begin
    #1;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_slt_undef();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
